// File: rtl/kbd_mmio_responder_if.sv
// Data-memory bus slice seen by the keyboard device.
//   sel           : access falls in the keyboard window (decoded upstream)
//   dmem_read_in  : CPU load request
//   dmem_write_in : CPU store request
//   pipe_stall    : pipeline frozen, no side effects may occur
//   dmem_addr     : word select within the window
//   data_from_reg : store data
//   dmem_data_out : combinational read data back to the CPU
interface kbd_mmio_responder_if;
  logic        sel;
  logic        dmem_read_in;
  logic        dmem_write_in;
  logic        pipe_stall;
  logic [1:0]  dmem_addr;
  logic [31:0] data_from_reg;
  logic [31:0] dmem_data_out;

  modport master (
    output sel, dmem_read_in, dmem_write_in, pipe_stall, dmem_addr, data_from_reg,
    input  dmem_data_out
  );

  modport slave (
    input  sel, dmem_read_in, dmem_write_in, pipe_stall, dmem_addr, data_from_reg,
    output dmem_data_out
  );
endinterface

// File: rtl/kbd_mmio_responder.sv
// Memory-mapped PS/2 keyboard receiver.
// Conditions the raw PS/2 lines, deframes 11-bit frames, buffers valid scan codes in a FIFO and
// exposes DATA / STATUS / CONTROL words on a combinational read path.
//   clk, rst  : system clock, asynchronous active-high reset
//   ps2_clk   : raw PS/2 clock (asynchronous)
//   ps2_data  : raw PS/2 data (asynchronous)
//   bus       : CPU data-memory slice (slave side)
//   kbd_irq   : FIFO non-empty
//   err_cnt   : bad/timed-out frame count, saturating at 255
module kbd_mmio_responder #(
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  kbd_mmio_responder_if.slave  bus,
  output logic                 kbd_irq,
  output logic [7:0]           err_cnt
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned FltW  = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW  = FIFO_AW + 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Input conditioning
  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_s, data_s;
  logic            filt_q;
  logic [FltW-1:0] flt_cnt_q;
  logic            fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Filtered level only follows the synchronised clock after FILTER_LEN consecutive mismatches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else if (clk_s == filt_q) begin
      flt_cnt_q <= '0;
    end else if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
      filt_q    <= clk_s;
      flt_cnt_q <= '0;
    end else begin
      flt_cnt_q <= flt_cnt_q + FltW'(1);
    end
  end

  assign fall = filt_q & ~clk_s & (flt_cnt_q == FltW'(FILTER_LEN - 1));

  // Receive FSM
  rx_state_e       state_q, state_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            push_q, push_d;
  logic [7:0]      push_byte_q, push_byte_d;
  logic [TmoW-1:0] tmo_q;
  logic            timeout;
  logic            err_inc;
  logic [7:0]      err_q;

  assign timeout = (state_q != StIdle) && !fall && (tmo_q == TmoW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    err_inc     = 1'b0;
    if (timeout) begin
      state_d = StIdle;
      err_inc = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_s) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = data_s;
          state_d = StStop;
        end
        StStop: begin
          // Odd parity across data and parity bits, plus a high stop bit.
          if (data_s && (^{shift_q, par_q})) begin
            push_d      = 1'b1;
            push_byte_d = shift_q;
          end else begin
            err_inc = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      tmo_q       <= (state_q == StIdle || fall) ? '0 : tmo_q + TmoW'(1);
      if (err_inc && err_q != 8'hff) err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;

  // FIFO and register side effects
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               ovf_q;
  logic               acc, nonempty, full, pop, ctrl_wr, flush, ovf_clr, push_ok, ovf_set;
  logic               unused_wdata;

  assign acc      = bus.sel & ~bus.pipe_stall;
  assign nonempty = (count_q != '0);
  assign full     = (count_q == CntW'(Depth));
  assign pop      = acc & bus.dmem_read_in & (bus.dmem_addr == 2'd0) & nonempty;
  assign ctrl_wr  = acc & bus.dmem_write_in & (bus.dmem_addr == 2'd2);
  assign flush    = ctrl_wr & bus.data_from_reg[0];
  assign ovf_clr  = ctrl_wr & bus.data_from_reg[1];
  // A same-cycle pop frees the slot for the incoming byte; flush discards it.
  assign push_ok  = push_q & (~full | pop) & ~flush;
  assign ovf_set  = push_q & full & ~pop & ~flush;
  assign unused_wdata = ^bus.data_from_reg[31:2];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        count_q <= count_q + CntW'(push_ok) - CntW'(pop);
      end
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    bus.dmem_data_out = '0;
    if (bus.sel) begin
      case (bus.dmem_addr)
        2'd0: if (nonempty) bus.dmem_data_out = {23'd0, 1'b1, mem_q[rd_ptr_q]};
        2'd1: begin
          bus.dmem_data_out[FIFO_AW:0]   = count_q;
          bus.dmem_data_out[FIFO_AW + 4] = ovf_q;
        end
        default: bus.dmem_data_out = '0;
      endcase
    end
  end

  assign kbd_irq = nonempty;

endmodule

// File: tb/tb_kbd_mmio_responder.sv
module tb_kbd_mmio_responder;
  localparam int FIFO_AW    = 4;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 200;
  localparam int H          = 20;  // half PS/2 clock period in system cycles
  localparam int DEPTH      = 1 << FIFO_AW;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data;
  logic       kbd_irq;
  logic [7:0] err_cnt;

  kbd_mmio_responder_if bus ();

  kbd_mmio_responder #(
    .FIFO_AW   (FIFO_AW),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus),
    .kbd_irq (kbd_irq),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] data;
    logic        irq;
    logic [7:0]  err;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mq[$];   // reference FIFO contents
  bit         m_ovf;
  int         m_err;
  int         total = 0;
  int         bad = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every unstalled read cycle is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.dmem_read_in && !bus.pipe_stall) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h expected none", bus.dmem_data_out);
      end else begin
        e = sbq.pop_front();
        check({e.nm, "_data"}, bus.dmem_data_out, e.data);
        check({e.nm, "_irq"}, {31'd0, kbd_irq}, {31'd0, e.irq});
        check({e.nm, "_err"}, {24'd0, err_cnt}, {24'd0, e.err});
      end
    end
  end

  function automatic void model_err();
    if (m_err < 255) m_err++;
  endfunction

  // Builds the expected word from the reference state; a DATA read also pops the model.
  function automatic void expect_read(input logic [1:0] a, input string nm, input bit sel_v);
    exp_t e;
    e.nm   = nm;
    e.irq  = (mq.size() != 0);
    e.err  = m_err[7:0];
    e.data = 32'd0;
    if (sel_v) begin
      if (a == 2'd0 && mq.size() != 0) begin
        e.data = {23'd0, 1'b1, mq[0]};
        void'(mq.pop_front());
      end else if (a == 2'd1) begin
        e.data = {22'd0, m_ovf, 3'd0, 5'(mq.size())};
      end
    end
    sbq.push_back(e);
  endfunction

  task automatic bus_read(input logic [1:0] a, input string nm, input bit sel_v = 1'b1);
    expect_read(a, nm, sel_v);
    bus.sel          = sel_v;
    bus.dmem_read_in = 1'b1;
    bus.dmem_addr    = a;
    cyc(1);
    bus.sel          = 1'b0;
    bus.dmem_read_in = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd2) begin
      if (d[0]) mq.delete();
      if (d[1]) m_ovf = 1'b0;
    end
    bus.sel           = 1'b1;
    bus.dmem_write_in = 1'b1;
    bus.dmem_addr     = a;
    bus.data_from_reg = d;
    cyc(1);
    bus.sel           = 1'b0;
    bus.dmem_write_in = 1'b0;
  endtask

  // Drives the first nbits bits of a frame; only complete frames update the model.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_bit = -1, input bit pop_at_push = 1'b0,
                            input int nbits = 11);
    logic [10:0] bits;
    bits = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch_bit == i) begin
        cyc(4);
        ps2_clk = 1'b0;
        cyc(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        cyc(H - 4 - (FILTER_LEN - 1));
      end else begin
        cyc(H);
      end
      ps2_clk = 1'b0;
      if (i == 10 && pop_at_push) begin
        // Filtered fall plus one cycle for the push register lands the push 11 edges out.
        cyc(10);
        bus_read(2'd0, "pop_at_push");
        cyc(H - 11);
      end else begin
        cyc(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(H);
    if (nbits == 11) begin
      if (!bad_par && !bad_stop) begin
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(b);
      end else begin
        model_err();
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_err = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.sel = 1'b0;
    bus.dmem_read_in = 1'b0;
    bus.dmem_write_in = 1'b0;
    bus.pipe_stall = 1'b0;
    bus.dmem_addr = 2'd0;
    bus.data_from_reg = 32'd0;
    model_reset();
    cyc(5);
    rst = 1'b0;
    cyc(5);

    bus_read(2'd1, "rst_status");
    bus_read(2'd0, "rst_data");
    bus_read(2'd2, "rst_ctrl");
    bus_read(2'd3, "rst_w3");

    // Single frame, read back, then empty
    send_frame(8'h1c, 1'b0, 1'b0);
    bus_read(2'd1, "t1_status");
    bus_read(2'd0, "t1_data");
    bus_read(2'd0, "t1_data_empty");
    bus_read(2'd1, "t1_status_empty");

    // Read with sel low must return zero and not pop
    send_frame(8'h33, 1'b0, 1'b0);
    bus_read(2'd0, "sel0", 1'b0);
    bus_read(2'd0, "sel0_after");

    // Overflow, drain in order, clear ovf
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0);
    bus_read(2'd1, "t2_status_full");
    for (int i = 0; i < 16; i++) bus_read(2'd0, "t2_drain");
    bus_write(2'd2, 32'd2);
    bus_read(2'd1, "t2_status_clr");

    // Bad parity and bad stop
    send_frame(8'h1c, 1'b1, 1'b0);
    send_frame(8'h1c, 1'b0, 1'b1);
    bus_read(2'd1, "t3_status");

    // Timeout mid-frame, then a good frame
    send_frame(8'h5a, 1'b0, 1'b0, -1, 1'b0, 5);
    cyc(TIMEOUT + 30);
    model_err();
    send_frame(8'h5a, 1'b0, 1'b0);
    bus_read(2'd0, "t4_data");

    // Short glitch mid-frame, then stalled read
    send_frame(8'h42, 1'b0, 1'b0, 4);
    send_frame(8'h43, 1'b0, 1'b0);
    bus.sel = 1'b1;
    bus.dmem_read_in = 1'b1;
    bus.dmem_addr = 2'd0;
    bus.pipe_stall = 1'b1;
    cyc(3);
    expect_read(2'd0, "t5_unstall", 1'b1);
    bus.pipe_stall = 1'b0;
    cyc(1);
    bus.sel = 1'b0;
    bus.dmem_read_in = 1'b0;
    bus_read(2'd1, "t5_status");
    bus_read(2'd0, "t5_data");

    // Full FIFO with push coinciding with a pop
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, -1, 1'b1);
    bus_read(2'd1, "t6_status_full");

    // Reset mid-frame; remaining bits are all high so no new start bit appears
    send_frame(8'hff, 1'b0, 1'b0, -1, 1'b0, 4);
    rst = 1'b1;
    model_reset();
    cyc(3);
    rst = 1'b0;
    for (int i = 4; i < 11; i++) begin
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    cyc(H);
    bus_read(2'd1, "t6_rst_status");
    bus_read(2'd0, "t6_rst_data");

    // Randomised mix
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 11));
      if (r <= 4) send_frame(8'($urandom), 1'b0, 1'b0);
      else if (r == 5) send_frame(8'($urandom), 1'b1, 1'b0);
      else if (r == 6) send_frame(8'($urandom), 1'b0, 1'b1);
      else if (r <= 8) bus_read(2'd0, "rnd_data");
      else if (r == 9) bus_read(2'd1, "rnd_status");
      else if (r == 10) bus_write(2'($urandom_range(0, 3)), 32'($urandom));
      else bus_read(2'($urandom_range(2, 3)), "rnd_other");
    end
    bus_read(2'd1, "rnd_final_status");
    while (mq.size() != 0) bus_read(2'd0, "rnd_drain");
    bus_read(2'd1, "rnd_empty_status");

    cyc(2);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
